// File: rtl/aes_dec_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 decrypt scheduler slice: scheduler state
// encoding, the AES block width, the length of the core load window and a
// small index-to-one-hot helper used for the requester-facing vectors.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int LOAD_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    // Requester index (0/1) to its one-hot position in a 2-bit vector.
    function automatic logic [1:0] onehot2(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/aes_dec_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_dec_scheduler_if
// Requester-side bundle of the decrypt scheduler.
//   req_valid/req_ready   : per-requester ciphertext handshake (one-hot grant)
//   req_ct0/req_ct1       : ciphertext blocks from requester 0 and 1
//   resp_valid/resp_ready : per-requester result handshake
//   resp_pt/resp_err      : shared plaintext and its abort qualifier
// master = the requesters, slave = the scheduler.
// ---------------------------------------------------------------------------
interface aes_dec_scheduler_if;

    logic [1:0]                       req_valid;
    logic [1:0]                       req_ready;
    logic [aes_pkg::AES_BLOCK_W-1:0]  req_ct0;
    logic [aes_pkg::AES_BLOCK_W-1:0]  req_ct1;
    logic [1:0]                       resp_valid;
    logic [1:0]                       resp_ready;
    logic [aes_pkg::AES_BLOCK_W-1:0]  resp_pt;
    logic                             resp_err;

    modport master (
        output req_valid, req_ct0, req_ct1, resp_ready,
        input  req_ready, resp_valid, resp_pt, resp_err
    );

    modport slave (
        input  req_valid, req_ct0, req_ct1, resp_ready,
        output req_ready, resp_valid, resp_pt, resp_err
    );

endinterface

// File: rtl/aes_dec_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way round-robin arbiter.
//   req[1:0]   : pending requests
//   last_grant : index of the requester granted most recently
//   grant[1:0] : one-hot grant; a lone request always wins, a tie goes to the
//                requester that was not granted last
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Grant selection from the request pattern and the previous winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_dec_scheduler.sv
// ---------------------------------------------------------------------------
// aes_dec_scheduler
// Shares one AES-128 inverse-cipher core between two requesters. A granted
// ciphertext is latched, loaded into the core by holding the core's reset for
// LOAD_CYCLES cycles, then the core is enabled until it reports ready. The
// plaintext is returned to the requester that owns the job. A watchdog aborts
// a job that stays in RUN for TIMEOUT cycles and returns resp_err=1, pt=0.
//   Clk, Rst           : clock, synchronous active-high reset
//   bus (slave)        : requester handshakes, ciphertexts, response
//   core_rst/en/ct     : drive the core's Rst, En and CT inputs
//   core_ry/core_pt    : core ready flag and plaintext
//   busy               : high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module aes_dec_scheduler
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int CW      = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    aes_dec_scheduler_if.slave      bus,
    output logic                    core_rst,
    output logic                    core_en,
    output logic [AES_BLOCK_W-1:0]  core_ct,
    input  logic                    core_ry,
    input  logic [AES_BLOCK_W-1:0]  core_pt,
    output logic                    busy
);

    sched_state_e            state_r,      state_s;
    logic                    last_grant_r, last_grant_s;
    logic                    owner_r,      owner_s;
    logic [AES_BLOCK_W-1:0]  ct_r,         ct_s;
    logic [AES_BLOCK_W-1:0]  pt_r,         pt_s;
    logic                    err_r,        err_s;
    logic [CW-1:0]           wd_r,         wd_s;
    logic [1:0]              load_cnt_r,   load_cnt_s;
    logic [1:0]              grant_s;

    rr_arb2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // State and datapath registers; reset drops any job in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            ct_r         <= '0;
            pt_r         <= '0;
            err_r        <= 1'b0;
            wd_r         <= '0;
            load_cnt_r   <= 2'd0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            owner_r      <= owner_s;
            ct_r         <= ct_s;
            pt_r         <= pt_s;
            err_r        <= err_s;
            wd_r         <= wd_s;
            load_cnt_r   <= load_cnt_s;
        end
    end

    // Next-state and datapath update for the job sequence.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        owner_s      = owner_r;
        ct_s         = ct_r;
        pt_s         = pt_r;
        err_s        = err_r;
        wd_s         = wd_r;
        load_cnt_s   = load_cnt_r;
        case (state_r)
            IDLE: begin
                // The arbiter only grants a valid requester, so a non-zero
                // grant in IDLE is the handshake.
                if (grant_s != 2'b00) begin
                    owner_s      = grant_s[1];
                    last_grant_s = grant_s[1];
                    if (grant_s[1]) begin
                        ct_s = bus.req_ct1;
                    end else begin
                        ct_s = bus.req_ct0;
                    end
                    load_cnt_s = 2'd0;
                    state_s    = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                wd_s = '0;
                if (load_cnt_r == 2'(LOAD_CYCLES - 1)) begin
                    state_s = RUN;
                end else begin
                    load_cnt_s = load_cnt_r + 2'd1;
                end
            end
            RUN: begin
                wd_s = wd_r + {{(CW-1){1'b0}}, 1'b1};
                // A ready core wins over a timeout in the same cycle.
                if (core_ry) begin
                    pt_s    = core_pt;
                    err_s   = 1'b0;
                    state_s = RESP;
                end else if (wd_r == CW'(TIMEOUT)) begin
                    pt_s    = '0;
                    err_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = RUN;
                end
            end
            RESP: begin
                // Only the owner's ready releases the response.
                if (bus.resp_ready[owner_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode; response data comes straight from registers so there is
    // no path from resp_ready to resp_pt.
    assign bus.req_ready  = ((state_r == IDLE) && !Rst) ? grant_s : 2'b00;
    assign bus.resp_valid = (state_r == RESP) ? onehot2(owner_r) : 2'b00;
    assign bus.resp_pt    = pt_r;
    assign bus.resp_err   = err_r;
    // The core is held in reset whenever the scheduler is, so a reset drops
    // the core's job as well.
    assign core_rst       = Rst | (state_r == LOAD);
    assign core_en        = (state_r == RUN);
    assign core_ct        = ct_r;
    assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_scheduler
// Self-checking bench for aes_dec_scheduler. A core stand-in returns a known
// plaintext for the reference vector and a fixed transform otherwise, with a
// latency derived from the ciphertext (10..73 enabled cycles) or never when
// 'hang' is set. A job-level model predicts every output on every cycle from
// the handshake cycle, the core latency and the watchdog limit.
// ---------------------------------------------------------------------------
module tb_aes_dec_scheduler;
    import aes_pkg::*;

    localparam int TIMEOUT = 63;
    localparam int CW      = 8;
    localparam logic [127:0] KNOWN_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KNOWN_PT = 128'h00112233445566778899aabbccddeeff;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    aes_dec_scheduler_if bus();
    logic         core_rst, core_en, busy;
    logic [127:0] core_ct;
    logic         core_ry = 1'b0;
    logic [127:0] core_pt = '0;

    aes_dec_scheduler #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus),
        .core_rst(core_rst), .core_en(core_en), .core_ct(core_ct),
        .core_ry(core_ry), .core_pt(core_pt), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- core stand-in ----------------
    function automatic int lat_of(input logic [127:0] ct);
        return int'(ct[5:0]) + 10;
    endfunction

    function automatic logic [127:0] core_fn(input logic [127:0] ct);
        if (ct == KNOWN_CT) return KNOWN_PT;
        return {ct[63:0], ct[127:64]} ^ 128'h5a5a_5a5a_0f0f_0f0f_c3c3_c3c3_1234_5678;
    endfunction

    logic         hang = 1'b0;
    logic [127:0] s_ct = '0;
    int           s_cnt = 0;
    always @(negedge Clk) begin
        if (core_rst) begin
            s_ct    <= core_ct;
            s_cnt   <= 0;
            core_ry <= 1'b0;
            core_pt <= '0;
        end else if (core_en && !hang && !core_ry) begin
            s_cnt <= s_cnt + 1;
            if (s_cnt + 1 == lat_of(s_ct)) begin
                core_ry <= 1'b1;
                core_pt <= core_fn(s_ct);
            end
        end
    end

    // ---------------- job-level model and per-cycle compare ----------------
    bit           m_active = 1'b0;
    bit           m_own    = 1'b0;
    bit           m_lg     = 1'b1;
    bit           m_err    = 1'b0;
    bit           m_just_reset = 1'b0;
    logic [127:0] m_ct = '0, m_pt = '0, m_core_ct = '0;
    int           m_n = 0, m_kend = 0;
    int           grant_log[$];
    // observations of DUT behaviour for the directed literal checks
    logic [1:0]   r_valid = 2'b00;
    logic [127:0] r_pt = '0;
    logic         r_err = 1'b0;
    int           r_rise = 0, r_run_entry = 0, resp_count = 0, rst_hi_count = 0;
    logic [1:0]   pv_rv = 2'b00;
    logic         pv_en = 1'b0;

    function automatic logic [1:0] rr_model(input logic [1:0] v, input bit lg);
        if (v == 2'b11) return lg ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(negedge Clk) begin
        int d;
        bit in_load, in_run, in_resp;
        logic [1:0] g, exp_rv;
        d       = cyc - m_n;
        in_load = m_active && (d < LOAD_CYCLES);
        in_run  = m_active && (d >= LOAD_CYCLES) && (d <= LOAD_CYCLES + m_kend);
        in_resp = m_active && (d > LOAD_CYCLES + m_kend);
        g       = (!m_active && !Rst) ? rr_model(bus.req_valid, m_lg) : 2'b00;
        exp_rv  = in_resp ? (m_own ? 2'b10 : 2'b01) : 2'b00;

        chk("req_ready",  bus.req_ready, g);
        chk("core_rst",   core_rst, Rst || in_load);
        chk("core_en",    core_en, in_run);
        chk("busy",       busy, m_active);
        chk("resp_valid", bus.resp_valid, exp_rv);
        chk("core_ct",    core_ct, m_core_ct);
        if (in_resp) begin
            chk("resp_pt",  bus.resp_pt, m_pt);
            chk("resp_err", bus.resp_err, m_err);
        end
        if (m_just_reset) begin
            chk("rst_resp_pt",  bus.resp_pt, 128'd0);
            chk("rst_resp_err", bus.resp_err, 1'b0);
            m_just_reset = 1'b0;
        end

        if (bus.resp_valid != 2'b00 && pv_rv == 2'b00) begin
            r_rise  = cyc;
            r_valid = bus.resp_valid;
            r_pt    = bus.resp_pt;
            r_err   = bus.resp_err;
            resp_count++;
        end
        if (core_en && !pv_en) r_run_entry = cyc;
        if (core_rst && !Rst) rst_hi_count++;
        pv_rv = bus.resp_valid;
        pv_en = core_en;

        // what the coming posedge does to the job
        if (Rst) begin
            m_active     = 1'b0;
            m_lg         = 1'b1;
            m_core_ct    = '0;
            m_just_reset = 1'b1;
        end else if (m_active) begin
            if (in_resp && bus.resp_ready[m_own]) m_active = 1'b0;
        end else if (g != 2'b00) begin
            m_active  = 1'b1;
            m_own     = g[1];
            m_lg      = g[1];
            m_ct      = g[1] ? bus.req_ct1 : bus.req_ct0;
            m_core_ct = m_ct;
            m_n       = cyc + 1;
            grant_log.push_back(int'(g[1]));
            if (hang || (lat_of(m_ct) - 1 > TIMEOUT)) begin
                m_kend = TIMEOUT;
                m_err  = 1'b1;
                m_pt   = '0;
            end else begin
                m_kend = lat_of(m_ct) - 1;
                m_err  = 1'b0;
                m_pt   = core_fn(m_ct);
            end
        end
    end

    // ---------------- stimulus ----------------
    int         remaining[2] = '{0, 0};
    int         rmode = 0;   // 0: always ready, 1: random, 2: held by the test
    logic [1:0] s_rv;

    function automatic logic [127:0] rand_ct();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] ct_lat(input int lat);
        logic [127:0] c;
        c = rand_ct();
        c[5:0] = 6'(lat - 10);
        return c;
    endfunction

    task automatic set_ct(input int i, input logic [127:0] c);
        if (i == 0) bus.req_ct0 = c;
        else        bus.req_ct1 = c;
    endtask

    task automatic step();
        logic [1:0] hs;
        @(negedge Clk);
        hs   = bus.req_valid & bus.req_ready;
        s_rv = bus.resp_valid;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                remaining[i]--;
                if (remaining[i] > 0) set_ct(i, rand_ct());
                else bus.req_valid[i] = 1'b0;
            end
        end
        if (rmode == 0)      bus.resp_ready = 2'b11;
        else if (rmode == 1) bus.resp_ready = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            step();
            if (!m_active && bus.req_valid == 2'b00) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: actual still busy required idle within 1000 cycles", name);
        end
    endtask

    task automatic wait_rv(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (s_rv != 2'b00) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: actual no resp_valid required resp_valid within 200 cycles", name);
        end
    endtask

    task automatic one_job(input logic [127:0] c);
        set_ct(0, c);
        remaining[0]     = 1;
        bus.req_valid[0] = 1'b1;
        wait_idle("job_done");
    endtask

    initial begin
        int rc;
        bus.req_valid  = 2'b00;
        bus.req_ct0    = '0;
        bus.req_ct1    = '0;
        bus.resp_ready = 2'b11;
        repeat (3) step();
        @(negedge Clk);
        chk("reset_busy",       busy, 1'b0);
        chk("reset_req_ready",  bus.req_ready, 2'b00);
        chk("reset_resp_valid", bus.resp_valid, 2'b00);
        chk("reset_core_en",    core_en, 1'b0);
        chk("reset_core_rst",   core_rst, 1'b1);
        chk("reset_resp_pt",    bus.resp_pt, 128'd0);
        @(posedge Clk);
        #1;

        // contention straight out of reset: grants 0,1,0,1
        grant_log.delete();
        Rst          = 1'b0;
        bus.req_ct0  = ct_lat(20);
        bus.req_ct1  = ct_lat(30);
        remaining    = '{2, 2};
        bus.req_valid = 2'b11;
        wait_idle("contention_done");
        chk("contention_jobs", 128'(grant_log.size()), 128'd4);
        for (int k = 0; k < grant_log.size() && k < 4; k++)
            chk("contention_order", 128'(grant_log[k]), 128'(k % 2));

        // reference vector
        rst_hi_count = 0;
        one_job(KNOWN_CT);
        chk("single_valid",   r_valid, 2'b01);
        chk("single_pt",      r_pt, KNOWN_PT);
        chk("single_err",     r_err, 1'b0);
        chk("single_rst_len", 128'(rst_hi_count), 128'd2);

        // response stall with requester 1 waiting
        rmode = 2;
        bus.resp_ready = 2'b00;
        set_ct(0, ct_lat(12));
        remaining[0] = 1;
        bus.req_valid[0] = 1'b1;
        step();
        step();
        set_ct(1, ct_lat(15));
        remaining[1] = 1;
        bus.req_valid[1] = 1'b1;
        wait_rv("stall_rv");
        chk("stall_owner", s_rv, 2'b01);
        repeat (20) step();
        @(negedge Clk);
        chk("stall_hold_valid", bus.resp_valid, 2'b01);
        chk("stall_hold_ready", bus.req_ready, 2'b00);
        chk("stall_hold_en",    core_en, 1'b0);
        @(posedge Clk);
        #1;
        bus.resp_ready = 2'b01;
        step();
        @(negedge Clk);
        chk("stall_next_grant", bus.req_ready, 2'b10);
        @(posedge Clk);
        #1;
        bus.req_valid[1] = 1'b0;
        remaining[1] = 0;
        bus.resp_ready = 2'b11;
        rmode = 0;
        wait_idle("stall_done");

        // non-owner ready is ignored
        rmode = 2;
        bus.resp_ready = 2'b00;
        set_ct(0, ct_lat(11));
        remaining[0] = 1;
        bus.req_valid[0] = 1'b1;
        wait_rv("nonowner_rv");
        for (int k = 0; k < 10; k++) begin
            bus.resp_ready = (k % 2 == 0) ? 2'b10 : 2'b00;
            step();
        end
        @(negedge Clk);
        chk("nonowner_hold", bus.resp_valid, 2'b01);
        @(posedge Clk);
        #1;
        bus.resp_ready = 2'b01;
        rmode = 0;
        wait_idle("nonowner_done");

        // watchdog with a core that never finishes, then a normal job
        hang = 1'b1;
        one_job(ct_lat(20));
        chk("wd_err",     r_err, 1'b1);
        chk("wd_pt",      r_pt, 128'd0);
        chk("wd_latency", 128'(r_rise - r_run_entry), 128'd64);
        hang = 1'b0;
        one_job(KNOWN_CT);
        chk("after_wd_err", r_err, 1'b0);
        chk("after_wd_pt",  r_pt, KNOWN_PT);

        // ready on the very cycle the watchdog expires, and one cycle later
        one_job(ct_lat(64));
        chk("edge_ready_err", r_err, 1'b0);
        one_job(ct_lat(65));
        chk("edge_late_err",  r_err, 1'b1);

        // reset pulse in the middle of RUN drops the job
        set_ct(0, ct_lat(50));
        remaining[0] = 1;
        bus.req_valid[0] = 1'b1;
        repeat (10) step();
        rc = resp_count;
        Rst = 1'b1;
        bus.req_valid = 2'b00;
        remaining[0] = 0;
        step();
        Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_busy",  busy, 1'b0);
        chk("midrst_rv",    bus.resp_valid, 2'b00);
        chk("midrst_en",    core_en, 1'b0);
        @(posedge Clk);
        #1;
        repeat (80) step();
        chk("midrst_no_resp", 128'(resp_count - rc), 128'd0);

        // random traffic
        rmode = 1;
        for (int t = 0; t < 3000; t++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 9) == 0) begin
                    set_ct(i, rand_ct());
                    remaining[i] = 1;
                    bus.req_valid[i] = 1'b1;
                end else if (bus.req_valid[i] && $urandom_range(0, 19) == 0) begin
                    bus.req_valid[i] = 1'b0;
                    remaining[i] = 0;
                end
            end
        end
        bus.req_valid = 2'b00;
        remaining = '{0, 0};
        rmode = 0;
        wait_idle("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual no finish required finish before time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/aes_dec_scheduler.md
# aes_dec_scheduler

Sequencer and round-robin arbiter that shares one AES-128 inverse-cipher core between two requesters. It accepts a ciphertext block from either requester and loads it into the core by pulsing the core's reset. It then enables the core until the core signals ready, and returns the plaintext to the originating requester. A watchdog aborts jobs that never complete. The block sits between the system bus/UART front ends and the decryptor state machine.

## Interface
- `TIMEOUT`, default 63: maximum cycles in RUN before abort. A normal job needs about 45 core cycles.
- `CW`, default 8: watchdog counter width. `TIMEOUT` must be < 2^CW.
- `Clk` in 1: clock. Scheduler registers update on posedge. The core samples on negedge.
- `Rst` in 1: reset, synchronous, active-high.
- `req_valid` in 2: requester i has a ciphertext pending.
- `req_ready` out 2: one-hot grant. Handshake on `req_valid[i] & req_ready[i]`.
- `req_ct0`, `req_ct1` in 128: ciphertext from requester 0 and 1.
- `resp_valid` out 2: one-hot, result available for requester i.
- `resp_ready` in 2: requester i accepts the result.
- `resp_pt` out 128: plaintext, shared by both requesters.
- `resp_err` out 1: qualifies `resp_pt`. 1 = watchdog abort, data invalid.
- `core_rst` out 1: drives the core's Rst.
- `core_en` out 1: drives the core's En.
- `core_ct` out 128: drives the core's CT input.
- `core_ry` in 1: core Ry.
- `core_pt` in 128: core PT.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, RUN, RESP.
- **IDLE**
  - Arbitration is combinational. If only one `req_valid` is set, grant it. If both are set, grant the requester not in `last_grant`.
  - `req_ready` = grant, only in IDLE.
  - On handshake: register the CT into `ct_q`, record `owner`, update `last_grant`, go to LOAD.
- **LOAD**
  - `core_rst`=1, `core_en`=0, `core_ct`=`ct_q`.
  - Lasts exactly 2 cycles, so the core sees at least one negedge with Rst high.
  - Clear the watchdog, then go to RUN.
- **RUN**
  - `core_rst`=0, `core_en`=1, and the watchdog increments each cycle.
  - If `core_ry`=1: capture `core_pt` into `pt_q`, set `err_q`=0, go to RESP.
  - Else if the counter == `TIMEOUT`: `pt_q`=0, `err_q`=1, go to RESP.
  - `core_ry` takes priority over a same-cycle timeout.
- **RESP**
  - `core_en`=0.
  - `resp_valid[owner]`=1, `resp_pt`=`pt_q`, `resp_err`=`err_q`.
  - Hold until `resp_ready[owner]`, then go to IDLE. `resp_ready` of the non-owner is ignored.
- `core_ct` = `ct_q` in all states, so the core keeps a stable CT.
- `core_rst` = `Rst` | (state==LOAD). Resetting the scheduler therefore also resets the core.
- Reset values:
  - state=IDLE, `last_grant`=1 (requester 0 wins the first tie).
  - `ct_q`, `pt_q`, `err_q`, watchdog and `owner` all 0.
  - Outputs: `req_ready`=0, `resp_valid`=0, `resp_pt`=0, `resp_err`=0, `core_en`=0, `core_rst`=1 while Rst is high, `busy`=0.
- A requester deasserting `req_valid` before grant is legal; no job starts.
- `Rst` asserted mid-job: the job is dropped silently, with no response and no error.

## Timing
- Handshake at posedge N, then LOAD covers N+1 to N+2 and RUN starts at N+3.
- `pt_q` registers at the first posedge where `core_ry`=1. `resp_valid` rises the following cycle.
- Minimum turnaround from response accept to the next grant is 1 cycle (IDLE).
- Back-to-back with both requesters valid, grants strictly alternate 0,1,0,1.
- Timeout abort: `resp_valid` rises `TIMEOUT`+1 cycles after RUN entry.
- `resp_valid` and `resp_pt` stay stable while stalled. No combinational path exists from `resp_ready` to `resp_pt`.

## Structure
- The shared package `aes_pkg` holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RESP=2'd3);
  - `AES_BLOCK_W`=128;
  - `LOAD_CYCLES`=2.
- One natural sub-module, `rr_arb2`: a 2-way round-robin arbiter taking `req[1:0]` and `last_grant` and producing a one-hot `grant`. It is combinational.
- The watchdog and FSM stay in the top block.

## Test plan
- **Single job:** key 000102030405060708090a0b0c0d0e0f, `req_ct0`=69c4e0d86a7b0430d8cdb78070b4c55a → `resp_valid`=2'b01, `resp_pt`=00112233445566778899aabbccddeeff, `resp_err`=0; `core_rst` is high exactly 2 cycles.
- **Contention:** both requesters valid from reset with different CTs → grant order 0,1,0,1 over 4 jobs; each `resp_pt` goes to its own owner.
- **Response stall:** hold `resp_ready`=0 for 20 cycles → `resp_valid` and `resp_pt` stay stable, `req_ready` stays 0 and `core_en` stays 0; a new grant comes 1 cycle after accept.
- **Watchdog:** core model with `core_ry` tied 0 → `resp_err`=1 and `resp_pt`=0 exactly 64 cycles after RUN entry; the next job completes normally.
- **Mid-job reset:** `Rst` pulsed during RUN → all outputs at reset values the next cycle, no response issued, `core_rst`=1 during the pulse.
- **Non-owner ready:** `resp_ready[1]` toggling while requester 0 owns the job → no effect until `resp_ready[0]`.
